// File: rtl/mem_arbiter_if.sv
// Request/grant, response and memory-side signals shared by the fetch unit, the LSU and the memory arbiter.
// The master modport is the requester/memory environment; the slave modport is the arbiter.
interface mem_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 9
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [2:0]    d_readdatasel;
  logic [1:0]    d_writedatasel;
  logic [1:0]    d_writeEnable;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_readdatasel;
  logic [1:0]    mem_writedatasel;
  logic [1:0]    mem_writeEnable;
  logic [DW-1:0] mem_rdata;

  modport master (
    output if_req, if_addr,
    output d_req, d_wr, d_addr, d_wdata, d_readdatasel, d_writedatasel, d_writeEnable,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_wr, mem_addr, mem_wdata, mem_readdatasel, mem_writedatasel, mem_writeEnable
  );

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_wr, d_addr, d_wdata, d_readdatasel, d_writedatasel, d_writeEnable,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_wr, mem_addr, mem_wdata, mem_readdatasel, mem_writedatasel, mem_writeEnable
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between fetch (IF) and load/store (D): D has priority, IF is forced
// through after MAX_WAIT denied cycles; read data returns one cycle after grant to its issuer.
module mem_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 9,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_D} rsp_state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0]    r_wait_cnt;
  rsp_state_t    r_rsp_state;
  rsp_state_t    w_rsp_next;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          w_if_win;
  logic          w_d_win;
  logic          w_if_rvalid;
  logic          w_d_rvalid;
  logic [DW-1:0] w_if_rdata;
  logic [DW-1:0] w_d_rdata;

  // Grants are gated by rst_n so nothing reaches memory while reset is held.
  always_comb begin
    w_if_win = rst_n & bus.if_req & (~bus.d_req | (r_wait_cnt == MAX_W));
    w_d_win  = rst_n & bus.d_req & ~w_if_win;
  end

  assign bus.if_gnt = w_if_win;
  assign bus.d_gnt  = w_d_win;

  always_comb begin
    bus.mem_wr           = 1'b0;
    bus.mem_addr         = '0;
    bus.mem_wdata        = '0;
    bus.mem_readdatasel  = 3'b000;
    bus.mem_writedatasel = 2'b00;
    bus.mem_writeEnable  = 2'b00;
    if (w_if_win) begin
      bus.mem_addr        = bus.if_addr;
      bus.mem_readdatasel = 3'b010;
    end else if (w_d_win) begin
      bus.mem_wr           = bus.d_wr;
      bus.mem_addr         = bus.d_addr;
      bus.mem_wdata        = bus.d_wdata;
      bus.mem_readdatasel  = bus.d_readdatasel;
      bus.mem_writedatasel = bus.d_writedatasel;
      bus.mem_writeEnable  = bus.d_writeEnable;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if (bus.if_req && !w_if_win) begin
      if (r_wait_cnt != MAX_W) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_state <= RSP_NONE;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_rsp_state <= w_rsp_next;
      if (r_rsp_state == RSP_IF) begin
        r_if_rdata <= bus.mem_rdata;
      end
      if (r_rsp_state == RSP_D) begin
        r_d_rdata <= bus.mem_rdata;
      end
    end
  end

  // The inactive side keeps presenting the last word it was returned.
  always_comb begin
    w_rsp_next  = RSP_NONE;
    w_if_rvalid = 1'b0;
    w_d_rvalid  = 1'b0;
    w_if_rdata  = r_if_rdata;
    w_d_rdata   = r_d_rdata;
    if (w_if_win) begin
      w_rsp_next = RSP_IF;
    end else if (w_d_win && !bus.d_wr) begin
      w_rsp_next = RSP_D;
    end
    case (r_rsp_state)
      RSP_IF: begin
        w_if_rvalid = 1'b1;
        w_if_rdata  = bus.mem_rdata;
      end
      RSP_D: begin
        w_d_rvalid = 1'b1;
        w_d_rdata  = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  assign bus.if_rvalid = w_if_rvalid;
  assign bus.if_rdata  = w_if_rdata;
  assign bus.d_rvalid  = w_d_rvalid;
  assign bus.d_rdata   = w_d_rdata;

endmodule
